// File: rtl/mem_word_responder.sv
// Word-memory responder: captures one request, waits a fixed number of cycles,
// then performs the access and acknowledges over a four-phase req/ack handshake.
module mem_word_responder #(
  parameter int unsigned ADDR_W      = 3,
  parameter int unsigned DATA_W      = 24,
  parameter int unsigned DEPTH       = 5,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req,
  input  logic              write_n,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              ack,
  output logic [DATA_W-1:0] rdata,
  output logic              err,
  output logic              busy
);

  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ACK} state_e;

  // Wait-state count must fit the 4-bit counter.
  if (WAIT_CYCLES > 15) begin : g_bad_wait
    $error("mem_word_responder: WAIT_CYCLES=%0d exceeds 15", WAIT_CYCLES);
  end

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                write_n_q, write_n_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                ack_q, ack_d;
  logic                err_q, err_d;
  logic                busy_q, busy_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic                mem_we;
  logic                in_range;

  assign in_range = (32'(addr_q) < DEPTH);

  // Next-state and access decode.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    write_n_d = write_n_q;
    rdata_d   = rdata_q;
    ack_d     = ack_q;
    err_d     = err_q;
    mem_we    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          addr_d    = addr;
          wdata_d   = wdata;
          write_n_d = write_n;
          cnt_d     = CNT_W'(WAIT_CYCLES);
          state_d   = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (!req) begin
          state_d = ST_IDLE;
        end else if (cnt_q == '0) begin
          state_d = ST_ACK;
          ack_d   = 1'b1;
          if (!in_range) begin
            rdata_d = '0;
            err_d   = 1'b1;
          end else if (!write_n_q) begin
            mem_we  = 1'b1;
            rdata_d = wdata_q;
            err_d   = 1'b0;
          end else begin
            rdata_d = mem_q[addr_q];
            err_d   = 1'b0;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_ACK: begin
        // rdata deliberately keeps its last value after the handshake closes.
        if (!req) begin
          ack_d   = 1'b0;
          err_d   = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      write_n_q <= 1'b1;
      rdata_q   <= '0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      write_n_q <= write_n_d;
      rdata_q   <= rdata_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
      if (mem_we) begin
        mem_q[addr_q] <= wdata_q;
      end
    end
  end

  assign ack   = ack_q;
  assign rdata = rdata_q;
  assign err   = err_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_mem_word_responder.sv
// Scoreboard bench for mem_word_responder: one instance with two wait states,
// one with zero wait states, random and directed accesses against a word-array model.
module tb_mem_word_responder;

  localparam int unsigned AW     = 3;
  localparam int unsigned DW     = 24;
  localparam int unsigned DEPTH  = 5;
  localparam int unsigned WAIT_A = 2;

  typedef struct {
    logic [DW-1:0] rdata;
    logic          err;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          write_n;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          req_a, ack_a, err_a, busy_a;
  logic [DW-1:0] rdata_a;
  logic          req_b, ack_b, err_b, busy_b;
  logic [DW-1:0] rdata_b;

  int n_tests = 0;
  int n_fail  = 0;

  exp_t          exp_q_a[$];
  exp_t          exp_q_b[$];
  logic [DW-1:0] model_a [DEPTH];
  logic [DW-1:0] model_b [DEPTH];
  logic          ack_a_prev = 1'b0;
  logic          ack_b_prev = 1'b0;

  always #5 clk = ~clk;

  mem_word_responder #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .WAIT_CYCLES(WAIT_A)) u_dut_a (
    .clk(clk), .reset_n(reset_n), .req(req_a), .write_n(write_n), .addr(addr),
    .wdata(wdata), .ack(ack_a), .rdata(rdata_a), .err(err_a), .busy(busy_a)
  );

  mem_word_responder #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .WAIT_CYCLES(0)) u_dut_b (
    .clk(clk), .reset_n(reset_n), .req(req_b), .write_n(write_n), .addr(addr),
    .wdata(wdata), .ack(ack_b), .rdata(rdata_b), .err(err_b), .busy(busy_b)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
    end
  endtask

  function automatic logic get_ack(input bit s);
    return s ? ack_b : ack_a;
  endfunction
  function automatic logic get_err(input bit s);
    return s ? err_b : err_a;
  endfunction
  function automatic logic get_busy(input bit s);
    return s ? busy_b : busy_a;
  endfunction
  function automatic logic [DW-1:0] get_rdata(input bit s);
    return s ? rdata_b : rdata_a;
  endfunction

  task automatic set_req(input bit s, input logic v);
    if (s) req_b = v;
    else   req_a = v;
  endtask

  // Reference: a plain word array; out-of-range addresses touch nothing.
  function automatic exp_t model_step(input bit s, input logic wn, input logic [AW-1:0] a,
                                      input logic [DW-1:0] d);
    exp_t e;
    if (int'(a) >= int'(DEPTH)) begin
      e.rdata = '0;
      e.err   = 1'b1;
    end else if (!wn) begin
      if (s) model_b[a] = d;
      else   model_a[a] = d;
      e.rdata = d;
      e.err   = 1'b0;
    end else begin
      e.rdata = s ? model_b[a] : model_a[a];
      e.err   = 1'b0;
    end
    return e;
  endfunction

  task automatic clear_models();
    for (int i = 0; i < int'(DEPTH); i++) begin
      model_a[i] = '0;
      model_b[i] = '0;
    end
  endtask

  // One full handshake: issue, measure latency, hold req, release.
  task automatic access(input bit s, input logic wn, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input int hold, input bit scramble);
    exp_t e;
    int   edges;
    bit   seen;
    e = model_step(s, wn, a, d);
    if (s) exp_q_b.push_back(e);
    else   exp_q_a.push_back(e);
    @(negedge clk);
    write_n = wn; addr = a; wdata = d;
    set_req(s, 1'b1);
    @(posedge clk); #1;
    check("busy_after_capture", 32'(get_busy(s)), 32'd1);
    if (scramble) begin
      addr    = AW'($urandom);
      wdata   = DW'($urandom);
      write_n = 1'($urandom);
    end
    edges = 0;
    seen  = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(posedge clk); #1;
      edges++;
      seen = get_ack(s);
    end
    check("ack_latency", 32'(edges), s ? 32'd1 : 32'(WAIT_A + 1));
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      check("ack_hold", 32'(get_ack(s)), 32'd1);
      check("rdata_hold", 32'(get_rdata(s)), 32'(e.rdata));
    end
    @(negedge clk);
    set_req(s, 1'b0);
    @(posedge clk); #1;
    check("ack_release", 32'(get_ack(s)), 32'd0);
    check("err_release", 32'(get_err(s)), 32'd0);
    check("busy_release", 32'(get_busy(s)), 32'd0);
    check("rdata_kept", 32'(get_rdata(s)), 32'(e.rdata));
  endtask

  // Monitors: compare response on every rising ack against the scoreboard.
  always @(negedge clk) begin
    if (ack_a && !ack_a_prev) begin
      if (exp_q_a.size() == 0) begin
        check("unexpected_ack_a", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q_a.pop_front();
        check("rdata_a", 32'(rdata_a), 32'(e.rdata));
        check("err_a", 32'(err_a), 32'(e.err));
      end
    end
    ack_a_prev = ack_a;
  end

  always @(negedge clk) begin
    if (ack_b && !ack_b_prev) begin
      if (exp_q_b.size() == 0) begin
        check("unexpected_ack_b", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q_b.pop_front();
        check("rdata_b", 32'(rdata_b), 32'(e.rdata));
        check("err_b", 32'(err_b), 32'(e.err));
      end
    end
    ack_b_prev = ack_b;
  end

  initial begin
    bit any_ack;
    reset_n = 1'b0;
    req_a = 1'b0; req_b = 1'b0;
    write_n = 1'b1; addr = '0; wdata = '0;
    clear_models();
    #1;
    check("rst_ack", 32'(ack_a), 32'd0);
    check("rst_err", 32'(err_a), 32'd0);
    check("rst_busy", 32'(busy_a), 32'd0);
    check("rst_rdata", 32'(rdata_a), 32'd0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    // Write then read back.
    access(1'b0, 1'b0, 3'd3, 24'hA5C3F0, 0, 1'b0);
    access(1'b0, 1'b1, 3'd3, 24'h000000, 0, 1'b0);

    // Out-of-range reads and write; in-range words untouched.
    access(1'b0, 1'b1, 3'd5, 24'h0, 0, 1'b0);
    access(1'b0, 1'b1, 3'd7, 24'h0, 0, 1'b0);
    access(1'b0, 1'b0, 3'd6, 24'h777777, 0, 1'b0);
    for (int i = 0; i < int'(DEPTH); i++) access(1'b0, 1'b1, AW'(i), 24'h0, 0, 1'b0);

    // Abort during wait: no ack, no memory change.
    @(negedge clk);
    write_n = 1'b0; addr = 3'd1; wdata = 24'h123456; req_a = 1'b1;
    @(negedge clk);
    req_a = 1'b0;
    any_ack = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      any_ack |= ack_a;
    end
    check("abort_no_ack", 32'(any_ack), 32'd0);
    check("abort_busy", 32'(busy_a), 32'd0);
    access(1'b0, 1'b1, 3'd1, 24'h0, 0, 1'b0);

    // Long ack hold with inputs changing after capture.
    access(1'b0, 1'b1, 3'd3, 24'h0, 5, 1'b1);
    access(1'b0, 1'b0, 3'd4, 24'h5A5A5A, 5, 1'b1);

    for (int n = 0; n < 40; n++) begin
      access(1'b0, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), DW'($urandom),
             $urandom_range(0, 3), 1'b1);
    end

    // Reset in the middle of a write's wait phase.
    @(negedge clk);
    write_n = 1'b0; addr = 3'd2; wdata = 24'hBEEF01; req_a = 1'b1;
    @(posedge clk); #3;
    reset_n = 1'b0;
    #1;
    check("midrst_ack", 32'(ack_a), 32'd0);
    check("midrst_busy", 32'(busy_a), 32'd0);
    check("midrst_err", 32'(err_a), 32'd0);
    req_a = 1'b0;
    clear_models();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    access(1'b0, 1'b1, 3'd2, 24'h0, 0, 1'b0);

    // Zero wait-state instance.
    access(1'b1, 1'b0, 3'd0, 24'hFFFFFF, 0, 1'b0);
    access(1'b1, 1'b1, 3'd0, 24'h0, 0, 1'b0);
    for (int n = 0; n < 20; n++) begin
      access(1'b1, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), DW'($urandom),
             $urandom_range(0, 2), 1'b1);
    end

    repeat (3) @(negedge clk);
    check("drained_a", 32'(exp_q_a.size()), 32'd0);
    check("drained_b", 32'(exp_q_b.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
